// File: rtl/sipo_mem.sv
// Serial-in, parallel-out frame collector: gathers NOUTPUTS words of IWIDTH bits
// into a parallel frame (slot 0 = first word) with valid/ready on both sides.
module sipo_mem #(
  parameter int IWIDTH   = 10,
  parameter int NOUTPUTS = 8,
  localparam int CW      = $clog2(NOUTPUTS),
  localparam int LW      = $clog2(NOUTPUTS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [IWIDTH-1:0]                in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             clear,
  output logic [NOUTPUTS-1:0][IWIDTH-1:0]  out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LW-1:0]                    level,
  output logic                             state_dbg
);

  // Handshake rule (both sides): a transfer happens on a rising clk edge where
  // valid && ready are both 1; ready never depends on the same-side valid.
  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic          last_slot;

  assign in_ready  = (state == COLLECT);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready && !clear;
  assign last_slot = (cnt == CW'(NOUTPUTS - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      COLLECT: begin
        if (clear) begin
          cnt_nxt = '0;
        end else if (accept) begin
          if (last_slot) begin
            cnt_nxt   = '0;
            state_nxt = FULL;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      FULL: begin
        // clear wins over out_ready; either way the frame leaves FULL
        if (clear || out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      level     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (state_nxt == FULL);
      level     <= (state_nxt == FULL) ? LW'(NOUTPUTS) : LW'(cnt_nxt);
      if (accept) out[cnt] <= in;
    end
  end

endmodule

// File: tb/tb_sipo_mem.sv
// Directed bench for sipo_mem: drivers push expected frames, a negedge monitor
// pops and compares each frame as out_valid rises and checks hold stability.
module tb_sipo_mem;
  localparam int IW = 10;
  localparam int N  = 8;
  localparam int W  = IW * N;
  localparam int LW = $clog2(N + 1);

  logic                    clk;
  logic                    rst_n;
  logic [IW-1:0]           in;
  logic                    in_valid;
  logic                    in_ready;
  logic                    clear;
  logic [N-1:0][IW-1:0]    out;
  logic                    out_valid;
  logic                    out_ready;
  logic [LW-1:0]           level;
  logic                    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_valid = 1'b0;
  logic [W-1:0] held;

  sipo_mem #(.IWIDTH(IW), .NOUTPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: got %0h expected no frame", out);
        end else begin
          chk("frame", out, exp_q.pop_front());
        end
      end else if (out_valid && prev_valid) begin
        chk("frame_stable", out, held);
      end
      prev_valid = out_valid;
      held       = out;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N-1:0][IW-1:0] f);
    exp_q.push_back(f);
    for (int k = 0; k < N; k++) begin
      in       = f[k];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0][IW-1:0] f;
    in = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset_out", out, '0);
    chk("reset_valid", out_valid, 0);
    chk("reset_level", level, 0);
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready", in_ready, 1);

    // async reset mid-frame after 3 words
    for (int k = 0; k < 3; k++) begin
      in = IW'(10'h050 + k); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    chk("partial_level", level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, '0);
    chk("async_rst_level", level, 0);
    chk("async_rst_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // back-to-back frame 0x001..0x008
    for (int k = 0; k < N; k++) f[k] = IW'(k + 1);
    send_frame(f);
    chk("full_valid", out_valid, 1);
    chk("full_level", level, 8);
    chk("full_in_ready", in_ready, 0);
    chk("full_slot0", out[0], 10'h001);
    chk("full_slot7", out[7], 10'h008);
    in = 10'h155; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    in_valid = 1'b0;
    chk("hold_frame", out, f);
    chk("hold_level", level, 8);

    // handshake and refill
    handshake();
    chk("hs_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_level", level, 0);
    for (int k = 0; k < N; k++) f[k] = IW'(10'h3FF - k);
    send_frame(f);
    chk("refill_slot0", out[0], 10'h3FF);
    chk("refill_slot7", out[7], 10'h3F8);
    handshake();

    // gapped input
    for (int k = 0; k < N; k++) f[k] = IW'(10'h100 + k);
    exp_q.push_back(f);
    for (int c = 0; c < 16; c++) begin
      in_valid = (c % 2 == 0);
      in       = (c % 2 == 0) ? IW'(10'h100 + c / 2) : 10'h0AA;
      tick();
      chk("gap_level", level, c / 2 + 1);
    end
    in_valid = 1'b0;
    handshake();

    // clear mid-frame drops the presented word
    for (int k = 0; k < 5; k++) begin
      in = IW'(10'h0C0 + k); in_valid = 1'b1; tick();
    end
    chk("pre_clear_level", level, 5);
    clear = 1'b1; in = 10'h2AA; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_level", level, 0);
    chk("clear_valid", out_valid, 0);
    for (int k = 0; k < N; k++) f[k] = IW'(10'h010 + k);
    send_frame(f);
    chk("after_clear_level", level, 8);
    handshake();

    // clear versus out_ready in FULL
    for (int k = 0; k < N; k++) f[k] = IW'(10'h200 + 3 * k);
    send_frame(f);
    chk("cvr_pre_valid", out_valid, 1);
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    chk("cvr_valid", out_valid, 0);
    chk("cvr_level", level, 0);
    chk("cvr_state", state_dbg, 0);
    chk("cvr_in_ready", in_ready, 1);

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
